// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and the mid-bit vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DEF_CLK_HZ = 12000000;
    localparam int unsigned DEF_BAUD   = 115200;

    // Oversample counter values at which a bit is sampled; the vote happens on the last one.
    localparam logic [3:0] SMP_A = 4'd7;
    localparam logic [3:0] SMP_B = 4'd8;
    localparam logic [3:0] SMP_C = 4'd9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-accumulator rate generator: one-clock tick at RATE Hz on average, no drift.
module uart_baud_tick #(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned RATE   = 1843200
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned W = $clog2(CLK_HZ) + 1;

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] sum;
    logic         tick_q, tick_d;

    // Add RATE each clock; wrap by CLK_HZ and flag the wrap as a tick.
    always_comb begin
        sum    = acc_q + W'(RATE);
        acc_d  = sum;
        tick_d = 1'b0;
        if (sum >= W'(CLK_HZ)) begin
            acc_d  = sum - W'(CLK_HZ);
            tick_d = 1'b1;
        end
    end

    // Accumulator and tick register; free-running except for reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample mid-bit majority vote,
// single-entry holding register with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_rx_i,
    input  logic       uart_rd_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_ferr_o,
    output logic       uart_ovr_o,
    output logic       uart_busy_o
);

    logic       tick;
    logic       rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t  state_q;
    logic [3:0] scnt_q;
    logic [2:0] bidx_q;
    logic [7:0] shreg_q;
    logic [1:0] smp_q;
    logic       deliver_q;
    logic       ferr_q;
    logic [7:0] dat_q, dat_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       vote;
    logic       at_vote;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .RATE   (OVERSAMPLE * BAUD)
    ) u_tick (
        .clk_i  (sys_clk_i),
        .rst_i  (sys_rst_i),
        .tick_o (tick)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign vote    = maj3(smp_q[0], smp_q[1], rx_s_q);
    assign at_vote = tick && (scnt_q == SMP_C);

    // Frame FSM: oversample counting, sampling, shifting and stop-bit check.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q   <= RX_IDLE;
            scnt_q    <= '0;
            bidx_q    <= '0;
            shreg_q   <= '0;
            smp_q     <= '0;
            deliver_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            deliver_q <= 1'b0;
            ferr_q    <= 1'b0;
            if (tick && state_q != RX_IDLE && state_q != RX_BREAK) begin
                scnt_q <= scnt_q + 4'd1;
                if (scnt_q == SMP_A) smp_q[0] <= rx_s_q;
                if (scnt_q == SMP_B) smp_q[1] <= rx_s_q;
            end
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= RX_START;
                        scnt_q  <= '0;
                    end
                end
                RX_START: begin
                    if (at_vote) begin
                        if (!vote) begin
                            state_q <= RX_DATA;
                            bidx_q  <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (at_vote) begin
                        shreg_q <= {vote, shreg_q[7:1]};
                        bidx_q  <= bidx_q + 3'd1;
                        if (bidx_q == 3'd7) state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (at_vote) begin
                        if (vote) begin
                            deliver_q <= 1'b1;
                            state_q   <= RX_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // Holding register next state: delivery wins over a plain read; full and unread means overrun.
    always_comb begin
        dat_d   = dat_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver_q) begin
            if (!valid_q || uart_rd_i) begin
                dat_d   = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (uart_rd_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            dat_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dat_q   <= dat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign uart_dat_o   = dat_q;
    assign uart_valid_o = valid_q;
    assign uart_ferr_o  = ferr_q;
    assign uart_ovr_o   = ovr_q;
    assign uart_busy_o  = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of normal frames plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam real CPB = 12000000.0 / 115200.0;  // clocks per bit at nominal baud

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] dat;
    logic       valid, ferr, ovr, busy;

    uart_rx #(
        .CLK_HZ (12000000),
        .BAUD   (115200)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .uart_rx_i    (rx),
        .uart_rd_i    (rd),
        .uart_dat_o   (dat),
        .uart_valid_o (valid),
        .uart_ferr_o  (ferr),
        .uart_ovr_o   (ovr),
        .uart_busy_o  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    // event counters maintained at negedge
    int ferr_cnt = 0, ovr_cnt = 0, busy_rise = 0, busy_fall = 0, valid_fall = 0;
    int last_ovr_cyc = 0;
    int last_start = 0;
    logic [7:0] got_q[$];

    initial begin : monitor
        logic pb, pv;
        pb = 1'b0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (ferr === 1'b1) ferr_cnt++;
            if (ovr === 1'b1) begin ovr_cnt++; last_ovr_cyc = cyc; end
            if (!pb && busy === 1'b1) busy_rise++;
            if (pb && busy === 1'b0) busy_fall++;
            if (pv && valid === 1'b0) valid_fall++;
            pb = (busy === 1'b1);
            pv = (valid === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-accurate 8N1 frame at pct percent of nominal baud; line left at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pct);
        real bp;
        int t0;
        logic [9:0] bits;
        bp = CPB * 100.0 / pct;
        bits = {stop, d, 1'b0};
        @(posedge clk);
        #1;
        t0 = cyc;
        last_start = t0;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            while (1) begin
                @(posedge clk);
                #1;
                if (cyc - t0 >= $rtoi(bp * (k + 1) + 0.5)) break;
            end
        end
    endtask

    // Wait (bounded) for valid, capture the byte, acknowledge for one clock.
    task automatic rd_once();
        int n;
        n = 0;
        @(negedge clk);
        while (valid !== 1'b1 && n < 1400) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_timeout: valid=%b after %0d clks, required 1", valid, n);
            return;
        end
        got_q.push_back(dat);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("rd_ack_valid_low", {31'd0, valid}, 32'd0);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp);
        if (got_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no byte captured, required 0x%0h", name, exp);
        end else begin
            check(name, {24'd0, got_q.pop_front()}, {24'd0, exp});
        end
    endtask

    // Align to the tick accumulator period (625 clocks for 12 MHz / 1.8432 MHz).
    task automatic align625();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 625 != 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         pct;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int f0, o0, o1, b0, bf0, vf0, rel, t3, target;
        vecs[0] = '{data: 8'h55, pct: 100, exp: 8'h55};
        vecs[1] = '{data: 8'hA3, pct: 100, exp: 8'hA3};
        vecs[2] = '{data: 8'hC5, pct: 102, exp: 8'hC5};
        vecs[3] = '{data: 8'hC5, pct: 98,  exp: 8'hC5};
        vecs[4] = '{data: 8'h80, pct: 100, exp: 8'h80};
        vecs[5] = '{data: 8'h01, pct: 100, exp: 8'h01};

        // reset state
        rst = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dat", {24'd0, dat}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        wait_clks(200);

        // back-to-back 0x00, 0xFF with stop bit as the only gap
        bf0 = busy_fall;
        f0 = ferr_cnt;
        fork
            begin send_frame(8'h00, 1'b1, 100); send_frame(8'hFF, 1'b1, 100); end
            begin rd_once(); rd_once(); end
        join
        wait_clks(200);
        check_got("b2b_first_00", 8'h00);
        check_got("b2b_second_FF", 8'hFF);
        check("b2b_busy_falls", busy_fall - bf0, 32'd2);
        check("b2b_no_ferr", ferr_cnt - f0, 32'd0);

        // framing error with line held low as a break
        f0 = ferr_cnt;
        b0 = busy_rise;
        send_frame(8'h3C, 1'b0, 100);
        wait_clks(3 * 104);
        @(negedge clk);
        check("brk_ferr_once", ferr_cnt - f0, 32'd1);
        check("brk_valid_low", {31'd0, valid}, 32'd0);
        check("brk_busy_held", {31'd0, busy}, 32'd1);
        check("brk_single_start", busy_rise - b0, 32'd1);
        rx = 1'b1;
        wait_clks(50);
        @(negedge clk);
        check("brk_released_idle", {31'd0, busy}, 32'd0);
        wait_clks(150);
        fork send_frame(8'h7E, 1'b1, 100); rd_once(); join
        wait_clks(200);
        check_got("after_brk_7E", 8'h7E);

        // 2-clock glitch on the idle line
        f0 = ferr_cnt;
        b0 = busy_rise;
        vf0 = valid_fall;
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(250);
        @(negedge clk);
        check("glitch_busy_rose", busy_rise - b0, 32'd1);
        check("glitch_busy_back", {31'd0, busy}, 32'd0);
        check("glitch_valid_low", {31'd0, valid}, 32'd0);
        check("glitch_no_ferr", ferr_cnt - f0, 32'd0);
        fork send_frame(8'h12, 1'b1, 100); rd_once(); join
        wait_clks(200);
        check_got("after_glitch_12", 8'h12);

        // overrun, then a read coinciding with the next delivery
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 100);
        wait_clks(150);
        @(negedge clk);
        check("ovr_first_valid", {31'd0, valid}, 32'd1);
        check("ovr_first_dat", {24'd0, dat}, 32'h11);
        align625();
        send_frame(8'h22, 1'b1, 100);
        rel = last_ovr_cyc - last_start;
        wait_clks(150);
        @(negedge clk);
        check("ovr_pulse_once", ovr_cnt - o0, 32'd1);
        check("ovr_old_dat_kept", {24'd0, dat}, 32'h11);
        check("ovr_valid_held", {31'd0, valid}, 32'd1);
        if (rel < 1 || rel > 2000) rel = 1000;
        o1 = ovr_cnt;
        vf0 = valid_fall;
        align625();
        t3 = cyc + 1;
        target = t3 + rel - 1;
        fork
            send_frame(8'h33, 1'b1, 100);
            begin
                @(negedge clk);
                while (cyc < target) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        wait_clks(150);
        @(negedge clk);
        check("coinc_dat_33", {24'd0, dat}, 32'h33);
        check("coinc_valid", {31'd0, valid}, 32'd1);
        check("coinc_no_ovr", ovr_cnt - o1, 32'd0);
        check("coinc_valid_no_dip", valid_fall - vf0, 32'd0);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("final_read_clears", {31'd0, valid}, 32'd0);
        wait_clks(100);

        // reset while the last data bit (high) of 0x99 is on the line
        fork
            send_frame(8'h99, 1'b1, 100);
            begin
                repeat (885) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("midrst_dat", {24'd0, dat}, 32'd0);
                check("midrst_valid", {31'd0, valid}, 32'd0);
                check("midrst_busy", {31'd0, busy}, 32'd0);
                check("midrst_ferr", {31'd0, ferr}, 32'd0);
                b0 = busy_rise;
            end
        join
        wait_clks(200);
        @(negedge clk);
        check("midrst_no_restart", busy_rise - b0, 32'd0);
        check("midrst_still_empty", {31'd0, valid}, 32'd0);

        // table of normal frames at nominal and skewed baud
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            fork send_frame(vecs[i].data, 1'b1, vecs[i].pct); rd_once(); join
            wait_clks(200);
            check_got($sformatf("vec%0d_dat", i), vecs[i].exp);
            check($sformatf("vec%0d_no_ferr", i), ferr_cnt - f0, 32'd0);
            check($sformatf("vec%0d_no_ovr", i), ovr_cnt - o0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #800000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
